// File: rtl/uart_cmd_rx_if.sv
// Signal bundle between the host UART line / command consumers and uart_cmd_rx.
// The slave modport is the receiver's view. The master modport is the view of
// whatever drives the serial line and watches the strobes.
interface uart_cmd_rx_if;
  logic        rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic        cmd_valid;
  logic        frame_err;
  logic        csum_err;
  logic        busy;

  modport master (
    output rx,
    input  byte_data, byte_valid, cmd, arg, cmd_valid, frame_err, csum_err, busy
  );

  modport slave (
    input  rx,
    output byte_data, byte_valid, cmd, arg, cmd_valid, frame_err, csum_err, busy
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with fixed-length command packet decoder (sync, cmd, 4 arg bytes LE).
// Optional build macro UART_CMD_RX_CHECKSUM_EN adds a trailing XOR checksum byte
// (cmd ^ arg bytes). Without it, packets are 6 bytes and csum_err is tied low.
module uart_cmd_rx #(
  parameter int         CLK_FREQ     = 200_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic          clk,
  input  logic          rst,
  uart_cmd_rx_if.slave  intf
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam int TMO = TIMEOUT_BITS * CPB;
  localparam int TW = $clog2(TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  localparam logic [2:0] B_IDLE = 3'd0;
  localparam logic [2:0] B_START = 3'd1;
  localparam logic [2:0] B_DATA = 3'd2;
  localparam logic [2:0] B_STOP = 3'd3;
  localparam logic [2:0] B_WAIT_HIGH = 3'd4;

  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_CMD = 2'd1;
  localparam logic [1:0] P_ARG = 2'd2;
`ifdef UART_CMD_RX_CHECKSUM_EN
  localparam logic [1:0] P_CSUM = 2'd3;
`endif

  // Saturating increment for the inter-byte gap counter.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TMO_LAST) ? v : v + 1'b1;
  endfunction

  logic          rx_p0, rx_p1, rx_p2;
  logic [2:0]    bstate;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_p0;
  logic [7:0]    byte_p1;
  logic          vld_p1;
  logic          ferr_p1;
  logic          start_det;

  logic [1:0]    pstate;
  logic [1:0]    idx;
  logic [7:0]    cmd_sh;
  logic [31:0]   arg_sh;
  logic [31:0]   arg_ins;
  logic [7:0]    cmd_p2;
  logic [31:0]   arg_p2;
  logic          vld_p2;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;
  logic          tmo_hit;
`ifdef UART_CMD_RX_CHECKSUM_EN
  logic [7:0]    csum_sh;
  logic          cerr_p2;
`endif

  // Stage p0/p1: two-flop synchronizer; p2 keeps the previous synced value for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= intf.rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign start_det = (bstate == B_IDLE) && rx_p2 && !rx_p1;

  // Bit-level FSM: mid-bit sampling, stop-bit check and break recovery.
  always_ff @(posedge clk) begin
    if (rst) begin
      bstate  <= B_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
      byte_p1 <= '0;
    end else begin
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
      case (bstate)
        B_IDLE: begin
          cnt <= '0;
          if (start_det) bstate <= B_START;
        end
        B_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            bstate  <= rx_p1 ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == CPB_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) bstate <= B_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt == CPB_LAST) begin
            cnt <= '0;
            if (rx_p1) begin
              byte_p1 <= shift_p0;
              vld_p1  <= 1'b1;
              bstate  <= B_IDLE;
            end else begin
              ferr_p1 <= 1'b1;
              bstate  <= B_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_WAIT_HIGH: begin
          if (!rx_p1) begin
            cnt <= '0;
          end else if (cnt == CPB_LAST) begin
            cnt    <= '0;
            bstate <= B_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  // LSB-first data shift register, loaded at each mid-bit data sample.
  always_ff @(posedge clk) begin
    if (bstate == B_DATA && cnt == CPB_LAST) shift_p0 <= {rx_p1, shift_p0[7:1]};
  end

  // Gap counter: restarts at each byte, stops once the next start bit is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_run <= 1'b0;
      tmo_cnt <= '0;
    end else if (vld_p1) begin
      tmo_run <= 1'b1;
      tmo_cnt <= '0;
    end else if (start_det) begin
      tmo_run <= 1'b0;
    end else if (tmo_run) begin
      tmo_cnt <= sat_inc(tmo_cnt);
    end
  end

  assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);

  always_comb begin
    arg_ins = arg_sh;
    arg_ins[{idx, 3'b000} +: 8] = byte_p1;
  end

  // Shadow assembly of the packet in progress; never visible on the outputs.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      if (pstate == P_CMD) begin
        cmd_sh <= byte_p1;
`ifdef UART_CMD_RX_CHECKSUM_EN
        csum_sh <= byte_p1;
`endif
      end else if (pstate == P_ARG) begin
        arg_sh <= arg_ins;
`ifdef UART_CMD_RX_CHECKSUM_EN
        csum_sh <= csum_sh ^ byte_p1;
`endif
      end
    end
  end

  // Stage p2: packet parser and command output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate  <= P_SYNC;
      idx     <= '0;
      cmd_p2  <= '0;
      arg_p2  <= '0;
      vld_p2  <= 1'b0;
`ifdef UART_CMD_RX_CHECKSUM_EN
      cerr_p2 <= 1'b0;
`endif
    end else begin
      vld_p2 <= 1'b0;
`ifdef UART_CMD_RX_CHECKSUM_EN
      cerr_p2 <= 1'b0;
`endif
      if (ferr_p1) begin
        pstate <= P_SYNC;
      end else if (vld_p1) begin
        case (pstate)
          P_SYNC: if (byte_p1 == SYNC_BYTE) pstate <= P_CMD;
          P_CMD: begin
            idx    <= '0;
            pstate <= P_ARG;
          end
          P_ARG: begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
`ifdef UART_CMD_RX_CHECKSUM_EN
              pstate <= P_CSUM;
`else
              cmd_p2 <= cmd_sh;
              arg_p2 <= arg_ins;
              vld_p2 <= 1'b1;
              pstate <= P_SYNC;
`endif
            end
          end
`ifdef UART_CMD_RX_CHECKSUM_EN
          P_CSUM: begin
            if (byte_p1 == csum_sh) begin
              cmd_p2 <= cmd_sh;
              arg_p2 <= arg_sh;
              vld_p2 <= 1'b1;
            end else begin
              cerr_p2 <= 1'b1;
            end
            pstate <= P_SYNC;
          end
`endif
          default: pstate <= P_SYNC;
        endcase
      end else if (pstate != P_SYNC && tmo_hit) begin
        pstate <= P_SYNC;
      end
    end
  end

  assign intf.byte_data  = byte_p1;
  assign intf.byte_valid = vld_p1;
  assign intf.frame_err  = ferr_p1;
  assign intf.cmd        = cmd_p2;
  assign intf.arg        = arg_p2;
  assign intf.cmd_valid  = vld_p2;
`ifdef UART_CMD_RX_CHECKSUM_EN
  assign intf.csum_err   = cerr_p2;
`else
  assign intf.csum_err   = 1'b0;
`endif
  assign intf.busy       = (bstate != B_IDLE) || (pstate != P_SYNC);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx at CLKS_PER_BIT = 16 (1600 Hz / 100 baud).
module tb_uart_cmd_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_rx_if intf ();

  uart_cmd_rx #(
    .CLK_FREQ(1600), .BAUD(100), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .rst(rst), .intf(intf)
  );

  int checks = 0;
  int passed = 0;
  int fe_cnt = 0;
  int ce_cnt = 0;
  int both_cnt = 0;
  logic [7:0]  exp_byte[$];
  logic [7:0]  obs_byte[$];
  logic [39:0] exp_cmd[$];
  logic [39:0] obs_cmd[$];
  logic [39:0] last_cmd = '0;

  // Monitor: records every strobe the DUT produces.
  always @(negedge clk) begin
    if (intf.byte_valid) obs_byte.push_back(intf.byte_data);
    if (intf.cmd_valid) obs_cmd.push_back({intf.cmd, intf.arg});
    if (intf.frame_err) fe_cnt++;
    if (intf.csum_err) ce_cnt++;
    if (intf.byte_valid && intf.frame_err) both_cnt++;
  end

  task automatic idle_bits(input int n);
    intf.rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    intf.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      intf.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    intf.rx = stop;
    repeat (CPB) @(negedge clk);
    if (stop) exp_byte.push_back(b);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [31:0] a, input logic bad_csum);
    logic [7:0] cs;
    cs = c ^ a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    send_byte(8'hA5, 1'b1);
    send_byte(c, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8], 1'b1);
`ifdef UART_CMD_RX_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'hF8) : cs, 1'b1);
`endif
    if (!bad_csum) exp_cmd.push_back({c, a});
  endtask

  task automatic flush;
    exp_byte.delete();
    obs_byte.delete();
    exp_cmd.delete();
    obs_cmd.delete();
    fe_cnt = 0;
    ce_cnt = 0;
  endtask

  task automatic test_reset;
    intf.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (intf.byte_valid !== 1'b0) $display("FAIL reset_byte_valid: got %b want 0", intf.byte_valid); else passed++;
    checks++; if (intf.byte_data !== 8'h00) $display("FAIL reset_byte_data: got %h want 00", intf.byte_data); else passed++;
    checks++; if (intf.cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", intf.cmd_valid); else passed++;
    checks++; if (intf.cmd !== 8'h00) $display("FAIL reset_cmd: got %h want 00", intf.cmd); else passed++;
    checks++; if (intf.arg !== 32'h0) $display("FAIL reset_arg: got %h want 0", intf.arg); else passed++;
    checks++; if (intf.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", intf.frame_err); else passed++;
    checks++; if (intf.csum_err !== 1'b0) $display("FAIL reset_csum_err: got %b want 0", intf.csum_err); else passed++;
    checks++; if (intf.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", intf.busy); else passed++;
    rst = 1'b0;
    idle_bits(2);
    flush();
  endtask

  task automatic test_single_byte;
    logic [7:0] got, want;
    flush();
    send_byte(8'h3C, 1'b1);
    idle_bits(2);
    checks++; if (obs_byte.size() != exp_byte.size()) $display("FAIL single_count: got %0d want %0d", obs_byte.size(), exp_byte.size()); else passed++;
    while (obs_byte.size() > 0 && exp_byte.size() > 0) begin
      got = obs_byte.pop_front(); want = exp_byte.pop_front();
      checks++; if (got !== want) $display("FAIL single_data: got %h want %h", got, want); else passed++;
    end
    checks++; if (fe_cnt != 0) $display("FAIL single_frame_err: got %0d want 0", fe_cnt); else passed++;
    checks++; if (intf.byte_data !== 8'h3C) $display("FAIL single_hold: got %h want 3c", intf.byte_data); else passed++;
  endtask

  task automatic test_packet;
    logic [7:0]  got, want;
    logic [39:0] gc, wc;
    flush();
    send_pkt(8'h01, 32'h12345678, 1'b0);
    idle_bits(2);
    checks++; if (obs_byte.size() != exp_byte.size()) $display("FAIL pkt_byte_count: got %0d want %0d", obs_byte.size(), exp_byte.size()); else passed++;
    while (obs_byte.size() > 0 && exp_byte.size() > 0) begin
      got = obs_byte.pop_front(); want = exp_byte.pop_front();
      checks++; if (got !== want) $display("FAIL pkt_byte: got %h want %h", got, want); else passed++;
    end
    checks++; if (obs_cmd.size() != 1) $display("FAIL pkt_cmd_count: got %0d want 1", obs_cmd.size()); else passed++;
    if (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      gc = obs_cmd.pop_front(); wc = exp_cmd.pop_front(); last_cmd = wc;
      checks++; if (gc !== wc) $display("FAIL pkt_cmd_arg: got %h want %h", gc, wc); else passed++;
    end
    checks++; if (intf.busy !== 1'b0) $display("FAIL pkt_busy: got %b want 0", intf.busy); else passed++;
  endtask

  task automatic test_frame_err;
    logic [39:0] gc, wc;
    flush();
    send_byte(8'h55, 1'b0);
    intf.rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle_bits(2);
    checks++; if (fe_cnt != 1) $display("FAIL ferr_count: got %0d want 1", fe_cnt); else passed++;
    checks++; if (obs_byte.size() != 0) $display("FAIL ferr_no_byte: got %0d want 0", obs_byte.size()); else passed++;
    send_pkt(8'h02, 32'h00000000, 1'b0);
    idle_bits(2);
    checks++; if (obs_cmd.size() != 1) $display("FAIL ferr_recover_count: got %0d want 1", obs_cmd.size()); else passed++;
    if (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      gc = obs_cmd.pop_front(); wc = exp_cmd.pop_front(); last_cmd = wc;
      checks++; if (gc !== wc) $display("FAIL ferr_recover_cmd: got %h want %h", gc, wc); else passed++;
    end
  endtask

  task automatic test_glitch;
    flush();
    intf.rx = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(3);
    checks++; if (obs_byte.size() != 0) $display("FAIL glitch_byte: got %0d want 0", obs_byte.size()); else passed++;
    checks++; if (fe_cnt != 0) $display("FAIL glitch_ferr: got %0d want 0", fe_cnt); else passed++;
    checks++; if (intf.busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", intf.busy); else passed++;
  endtask

  task automatic test_timeout;
    logic [39:0] gc, wc;
    flush();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h11, 1'b1);
    idle_bits(25);
    checks++; if (intf.busy !== 1'b0) $display("FAIL tmo_busy: got %b want 0", intf.busy); else passed++;
    send_pkt(8'h08, 32'h00000001, 1'b0);
    idle_bits(2);
    checks++; if (obs_cmd.size() != 1) $display("FAIL tmo_cmd_count: got %0d want 1", obs_cmd.size()); else passed++;
    if (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      gc = obs_cmd.pop_front(); wc = exp_cmd.pop_front(); last_cmd = wc;
      checks++; if (gc !== wc) $display("FAIL tmo_cmd: got %h want %h", gc, wc); else passed++;
    end
  endtask

`ifdef UART_CMD_RX_CHECKSUM_EN
  task automatic test_csum_err;
    flush();
    send_pkt(8'h03, 32'h04030201, 1'b1);
    idle_bits(2);
    checks++; if (ce_cnt != 1) $display("FAIL csum_err_count: got %0d want 1", ce_cnt); else passed++;
    checks++; if (obs_cmd.size() != 0) $display("FAIL csum_no_cmd: got %0d want 0", obs_cmd.size()); else passed++;
    checks++; if ({intf.cmd, intf.arg} !== last_cmd) $display("FAIL csum_hold: got %h want %h", {intf.cmd, intf.arg}, last_cmd); else passed++;
  endtask
`endif

  task automatic test_rst_mid;
    logic [39:0] gc, wc;
    flush();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    intf.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    intf.rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (intf.byte_data !== 8'h00) $display("FAIL rst_byte_data: got %h want 00", intf.byte_data); else passed++;
    checks++; if (intf.cmd !== 8'h00) $display("FAIL rst_cmd: got %h want 00", intf.cmd); else passed++;
    checks++; if (intf.arg !== 32'h0) $display("FAIL rst_arg: got %h want 0", intf.arg); else passed++;
    checks++; if (intf.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", intf.busy); else passed++;
    checks++; if ({intf.byte_valid, intf.cmd_valid, intf.frame_err, intf.csum_err} !== 4'b0) $display("FAIL rst_strobes: got %b want 0000", {intf.byte_valid, intf.cmd_valid, intf.frame_err, intf.csum_err}); else passed++;
    idle_bits(30);
    checks++; if (obs_byte.size() != 3) $display("FAIL rst_byte_count: got %0d want 3", obs_byte.size()); else passed++;
    checks++; if (obs_cmd.size() != 0 || fe_cnt != 0 || ce_cnt != 0) $display("FAIL rst_no_strobe: got cmd %0d fe %0d ce %0d want 0", obs_cmd.size(), fe_cnt, ce_cnt); else passed++;
    flush();
    send_pkt(8'h5A, 32'hDEADBEEF, 1'b0);
    idle_bits(2);
    checks++; if (obs_cmd.size() != 1) $display("FAIL rst_recover_count: got %0d want 1", obs_cmd.size()); else passed++;
    if (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      gc = obs_cmd.pop_front(); wc = exp_cmd.pop_front();
      checks++; if (gc !== wc) $display("FAIL rst_recover_cmd: got %h want %h", gc, wc); else passed++;
    end
  endtask

  task automatic test_exclusive;
    checks++; if (both_cnt != 0) $display("FAIL byte_and_ferr_same_cycle: got %0d want 0", both_cnt); else passed++;
`ifndef UART_CMD_RX_CHECKSUM_EN
    checks++; if (ce_cnt != 0) $display("FAIL csum_err_tied: got %0d want 0", ce_cnt); else passed++;
`endif
  endtask

  initial begin
    intf.rx = 1'b1;
    test_reset();
    test_single_byte();
    test_packet();
    test_frame_err();
    test_glitch();
    test_timeout();
`ifdef UART_CMD_RX_CHECKSUM_EN
    test_csum_err();
`endif
    test_rst_mid();
    test_exclusive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
